fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined RISC-V core. Owns the architectural fetch PC, issues word reads to instruction memory, and buffers returned instructions in a 2-entry queue for decode. Consumes the redirect (`pcWriteEnable`/`pcWriteData`) produced by the write-back controller, and supplies the `PC` value that the controller pipelines internally.

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RISC-V fetch stage with one outstanding imem read and a 2-entry decode queue.
// Optional static JAL prediction is enabled by defining FETCH_JAL_PREDICT_EN.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pcWriteEnable,
  input  logic [ADDR_WIDTH-1:0] pcWriteData,
  input  logic                  stall,
  output logic                  imemReq,
  output logic [ADDR_WIDTH-1:0] imemAddr,
  input  logic                  imemValid,
  input  logic [31:0]           imemData,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic                  instrValid,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instrPC,
  output logic                  instrPredTaken
);

  typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           data;
    logic                  pred;
  } entry_t;

  state_t                state, stateNext;
  entry_t                q0, q1, pushEntry;
  logic [1:0]            count;
  logic                  push, pop, isJal;
  logic [ADDR_WIDTH-1:0] pcStep;

`ifdef FETCH_JAL_PREDICT_EN
  assign isJal  = (imemData[6:0] == 7'b1101111);
  assign pcStep = isJal ? {{(ADDR_WIDTH-21){imemData[31]}}, imemData[31], imemData[19:12],
                           imemData[20], imemData[30:21], 1'b0}
                        : ADDR_WIDTH'(4);
`else
  assign isJal  = 1'b0;
  assign pcStep = ADDR_WIDTH'(4);
`endif

  assign pushEntry = '{pc: PC, data: imemData, pred: isJal};
  assign pop       = (count != 2'd0) && !stall;

  // NOTE: combinational logic uses blocking '=' with every output defaulted first, so no
  // latch can be inferred; state registers below use non-blocking '<=' only.
  always_comb begin
    stateNext = state;
    imemReq   = 1'b0;
    push      = 1'b0;
    unique case (state)
      REQ: begin
        imemReq = (count < 2'd2) && !pcWriteEnable && !reset;
        if (imemReq) stateNext = WAIT;
      end
      WAIT: begin
        if (imemValid) begin
          push      = !pcWriteEnable;
          stateNext = REQ;
        end else if (pcWriteEnable) begin
          stateNext = DROP;
        end
      end
      DROP: if (imemValid) stateNext = REQ;
      default: stateNext = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= REQ;
    else       state <= stateNext;
  end

  // NOTE: the queue entries are reset (not just the count) because the head is visible on
  // instr/instrPC and those outputs must read zero straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      PC    <= RESET_PC;
      count <= 2'd0;
      q0    <= '0;
      q1    <= '0;
    end else if (pcWriteEnable) begin
      // A redirect wins: flush everything, including a push landing this cycle.
      PC    <= {pcWriteData[ADDR_WIDTH-1:2], 2'b00};
      count <= 2'd0;
    end else begin
      if (push) PC <= PC + pcStep;
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) q0 <= pushEntry;
          else               q1 <= pushEntry;
          count <= count + 2'd1;
        end
        2'b01: begin
          q0    <= q1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            q0 <= q1;
            q1 <= pushEntry;
          end else begin
            q0 <= pushEntry;
          end
        end
        default: ;
      endcase
    end
  end

  assign imemAddr       = PC;
  assign instrValid     = (count != 2'd0);
  assign instr          = q0.data;
  assign instrPC        = q0.pc;
  assign instrPredTaken = q0.pred;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a
// transaction-level model (queue of fetched entries, outstanding/discard flags, memory model).
module tb_fetch_unit;

  localparam int          AW       = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_JAL_PREDICT_EN
  localparam bit PREDICT = 1'b1;
`else
  localparam bit PREDICT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, pcWriteEnable, stall, imemReq, imemValid, instrValid, instrPredTaken;
  logic [AW-1:0] pcWriteData, imemAddr, PC, instrPC;
  logic [31:0]   imemData, instr;

  fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .pcWriteEnable(pcWriteEnable), .pcWriteData(pcWriteData),
    .stall(stall), .imemReq(imemReq), .imemAddr(imemAddr), .imemValid(imemValid),
    .imemData(imemData), .PC(PC), .instrValid(instrValid), .instr(instr),
    .instrPC(instrPC), .instrPredTaken(instrPredTaken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        pred;
  } entry_t;

  // Reference model state
  entry_t      mq[$];
  logic [31:0] mPC;
  bit          mOut, mDrop;
  // Memory model state
  bit          memBusy, staleDue;
  logic [31:0] memAddr;
  int          memCnt;
  int          fixedLat;   // 0 selects a random latency of 1..3 cycles
  int          jalMode;    // 0: all NOP, 1: random mix, 2: JAL +16 at address 0 only
  int          vectors, miscompares;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] hashOf(input logic [31:0] a);
    return (a ^ 32'h5A5A_1234) * 32'h9E37_79B1;
  endfunction

  function automatic bit isJalAt(input logic [31:0] a);
    logic [31:0] h = hashOf(a);
    if (jalMode == 2) return a == 32'd0;
    return jalMode == 1 && h[31:29] == 3'd0;
  endfunction

  function automatic int jalOffAt(input logic [31:0] a);
    logic [31:0] h = hashOf(a);
    if (jalMode == 2) return 16;
    return (int'(h[9:2]) - 128) * 4;
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] h = hashOf(a);
    logic [20:0] imm;
    if (isJalAt(a)) begin
      imm = 21'(jalOffAt(a));
      return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'h6F};
    end
    if (jalMode != 1)    return 32'h0000_0013;
    if (h[28:27] == 2'd0) return {h[31:7], 7'h63};   // branch: never predicted
    return {h[31:7], 7'h13};
  endfunction

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input bit rst, input bit st, input bit we, input logic [31:0] wd);
    bit          v, expReq;
    logic [31:0] d, reqAddr;
    entry_t      e;
    @(negedge clk);
    v = 1'b0;
    d = 32'h0;
    if (staleDue && !rst) begin
      v        = 1'b1;
      d        = $urandom;
      staleDue = 1'b0;
    end else if (memBusy && memCnt == 0) begin
      v = 1'b1;
      d = memWord(memAddr);
    end
    reset = rst; stall = st; pcWriteEnable = we; pcWriteData = wd;
    imemValid = v; imemData = d;
    expReq = !rst && !we && !mOut && mq.size() < 2;
    #1;
    check("imemReq", imemReq, expReq);
    check("imemAddr", imemAddr, mPC);
    check("PC", PC, mPC);
    check("instrValid", instrValid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("instr", instr, mq[0].data);
      check("instrPC", instrPC, mq[0].pc);
      check("instrPredTaken", instrPredTaken, mq[0].pred);
    end

    if (rst) begin
      if (memBusy) staleDue = 1'b1;
      memBusy = 1'b0;
      mPC = RESET_PC; mq.delete(); mOut = 1'b0; mDrop = 1'b0;
    end else begin
      reqAddr = mPC;
      if (v) memBusy = 1'b0;
      else if (memBusy) memCnt--;
      if (!we && mq.size() != 0 && !st) void'(mq.pop_front());
      if (v && mOut) begin
        if (!mDrop && !we) begin
          e.pc   = mPC;
          e.data = d;
          e.pred = PREDICT && isJalAt(mPC);
          mq.push_back(e);
          mPC = e.pred ? mPC + 32'(jalOffAt(e.pc)) : mPC + 32'd4;
        end
        mOut = 1'b0; mDrop = 1'b0;
      end else if (we && mOut) begin
        mDrop = 1'b1;
      end
      if (we) begin
        mq.delete();
        mPC = {wd[31:2], 2'b00};
      end
      if (expReq) begin
        mOut    = 1'b1;
        memBusy = 1'b1;
        memAddr = reqAddr;
        memCnt  = ((fixedLat != 0) ? fixedLat : int'($urandom_range(1, 3))) - 1;
      end
    end
  endtask

  task automatic doReset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    staleDue = 1'b0;
    check("rst.PC", PC, RESET_PC);
    check("rst.instrValid", instrValid, 1'b0);
    check("rst.instr", instr, 32'h0);
    check("rst.instrPC", instrPC, 32'h0);
    check("rst.pred", instrPredTaken, 1'b0);
    check("rst.imemReq", imemReq, 1'b0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; pcWriteEnable = 1'b0; pcWriteData = '0;
    imemValid = 1'b0; imemData = '0;
    mPC = RESET_PC; mOut = 1'b0; mDrop = 1'b0;
    memBusy = 1'b0; staleDue = 1'b0; memAddr = '0; memCnt = 0;
    vectors = 0; miscompares = 0;
    fixedLat = 1; jalMode = 0;

    // Best-case sequence with 1-cycle memory
    doReset();
    for (int c = 0; c < 7; c++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check("seq.req", imemReq, c % 2 == 0);
      if (c % 2 == 0) check("seq.addr", imemAddr, 32'(2 * c));
      check("seq.valid", instrValid, c >= 2 && c % 2 == 0);
      if (c >= 2 && c % 2 == 0) check("seq.instrPC", instrPC, 32'(2 * c - 4));
    end

    // Stall for 10 cycles: queue holds PC 0 and 4, request line idles
    doReset();
    for (int c = 0; c < 10; c++) step(1'b0, 1'b1, 1'b0, 32'h0);
    check("stall.req", imemReq, 1'b0);
    check("stall.head", instrPC, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("stall.pop0", instrPC, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("stall.pop1", instrPC, 32'h4);

    // Redirect while waiting, response arrives 3 cycles later and is discarded
    fixedLat = 4;
    doReset();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0103);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("drop.empty", instrValid, 1'b0);
    check("drop.req", imemReq, 1'b0);
    check("drop.PC", PC, 32'h100);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("drop.reqAfter", imemReq, 1'b1);
    check("drop.addrAfter", imemAddr, 32'h100);

    // Redirect coinciding with a response and a pop
    fixedLat = 1;
    doReset();
    for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0200);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("same.empty", instrValid, 1'b0);
    check("same.req", imemReq, 1'b1);
    check("same.addr", imemAddr, 32'h200);

    // PC wrap from the top of the address space
    doReset();
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("wrap.addr", imemAddr, 32'h0);
    check("wrap.instrPC", instrPC, 32'hFFFF_FFFC);

    // Reset mid-WAIT followed by a stale response
    fixedLat = 3;
    doReset();
    step(1'b0, 1'b0, 1'b1, 32'h0000_0040);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("stale.PC", PC, RESET_PC);
    check("stale.req", imemReq, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("stale.noPush", instrValid, 1'b0);

    // JAL at address 0 (jal x0,+16)
    fixedLat = 1; jalMode = 2;
    doReset();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("jal.instr", instr, 32'h0100_006F);
    check("jal.addr", imemAddr, PREDICT ? 32'd16 : 32'd4);
    check("jal.pred", instrPredTaken, PREDICT);

    // Randomized traffic
    fixedLat = 0; jalMode = 1;
    doReset();
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] wd;
      wd = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 19) == 0, wd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
